// File: rtl/cordic_prestage_if.sv
// Stream interface for the CORDIC pre-stage: angle input stream and
// initial (x, y, z) output stream with quadrant and sequence tags.
interface cordic_prestage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] angle_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] x_out;
   logic [31:0] y_out;
   logic [31:0] z_out;
   logic        quad_neg;
   logic [7:0]  seq_out;
   logic        range_err;

   modport slave (
      input  in_valid, angle_in, out_ready,
      output in_ready, out_valid, x_out, y_out, z_out, quad_neg, seq_out, range_err
   );

   modport master (
      output in_valid, angle_in, out_ready,
      input  in_ready, out_valid, x_out, y_out, z_out, quad_neg, seq_out, range_err
   );
endinterface

// File: rtl/cordic_prestage.sv
// CORDIC pre-stage: folds the input angle into [-pi/2, pi/2] and buffers it in a
// 2-entry FIFO. Define CORDIC_PRESTAGE_CLAMP_EN to clamp angles beyond +/-pi.
module cordic_prestage #(
   parameter logic [31:0] K_INIT  = 32'h136E9DB5,
   parameter logic [31:0] PI_HALF = 32'h3243F6A9,
   parameter logic [31:0] PI      = 32'h6487ED51
) (
   input logic              clk,
   input logic              rst,
   cordic_prestage_if.slave io
);

   localparam logic signed [31:0] PI_S  = PI;
   localparam logic signed [31:0] NPI_S = -PI_S;
   localparam logic signed [31:0] PH_S  = PI_HALF;
   localparam logic signed [31:0] NPH_S = -PH_S;

   typedef struct packed {
      logic        ld;
      logic [31:0] z;
      logic        q;
      logic [7:0]  seq;
   } ent_t;

   ent_t              head_q, head_d, tail_q, tail_d, new_e;
   logic [1:0]        cnt_q, cnt_d;
   logic              in_ready_q, in_ready_d;
   logic [7:0]        seq_q, seq_d;
   logic              push, pop;
   logic signed [31:0] ang;
`ifdef CORDIC_PRESTAGE_CLAMP_EN
   logic              err_q, err_d;
`endif

   always_comb begin
      push = io.in_valid && in_ready_q;
      pop  = (cnt_q != 2'd0) && io.out_ready;
      ang  = $signed(io.angle_in);
`ifdef CORDIC_PRESTAGE_CLAMP_EN
      err_d = err_q;
      if (ang > PI_S) begin
         ang = PI_S;
         if (push) err_d = 1'b1;
      end else if (ang < NPI_S) begin
         ang = NPI_S;
         if (push) err_d = 1'b1;
      end
`endif
      new_e.ld  = 1'b1;
      new_e.seq = seq_q;
      if (ang > PH_S) begin
         new_e.z = ang - PI_S;
         new_e.q = 1'b1;
      end else if (ang < NPH_S) begin
         new_e.z = ang + PI_S;
         new_e.q = 1'b1;
      end else begin
         new_e.z = ang;
         new_e.q = 1'b0;
      end

      // Head doubles as the output register so it keeps its value once drained.
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = new_e;
            else               tail_d = new_e;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            if (cnt_q == 2'd2) head_d = tail_q;
            cnt_d = cnt_q - 2'd1;
         end
         // push needs cnt<2 and pop needs cnt>0, so occupancy is exactly 1 here
         2'b11:   head_d = new_e;
         default: ;
      endcase
      seq_d      = push ? seq_q + 8'd1 : seq_q;
      in_ready_d = (cnt_d < 2'd2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         cnt_q      <= 2'd0;
         in_ready_q <= 1'b0;
         seq_q      <= 8'd0;
`ifdef CORDIC_PRESTAGE_CLAMP_EN
         err_q      <= 1'b0;
`endif
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         cnt_q      <= cnt_d;
         in_ready_q <= in_ready_d;
         seq_q      <= seq_d;
`ifdef CORDIC_PRESTAGE_CLAMP_EN
         err_q      <= err_d;
`endif
      end
   end

   assign io.in_ready  = in_ready_q;
   assign io.out_valid = (cnt_q != 2'd0);
   assign io.x_out     = head_q.ld ? K_INIT : 32'd0;
   assign io.y_out     = 32'd0;
   assign io.z_out     = head_q.z;
   assign io.quad_neg  = head_q.q;
   assign io.seq_out   = head_q.seq;
`ifdef CORDIC_PRESTAGE_CLAMP_EN
   assign io.range_err = err_q;
`else
   assign io.range_err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_prestage.sv
// Scoreboard bench for cordic_prestage: expected samples are queued on accept
// and compared in order when the DUT hands them downstream.
module tb_cordic_prestage;

   localparam logic [31:0] K_INIT = 32'h136E9DB5;
   localparam logic signed [31:0] PH = 32'h3243F6A9;
   localparam logic signed [31:0] PI = 32'h6487ED51;

   typedef struct packed {
      logic [31:0] z;
      logic        q;
      logic [7:0]  seq;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   cordic_prestage_if io();

   cordic_prestage dut (.clk(clk), .rst(rst), .io(io));

   always #5 clk = ~clk;

   exp_t       sb[$];
   int         tests = 0;
   int         fails = 0;
   int         npop  = 0;
   logic [7:0] exp_seq;

   function automatic exp_t model(input logic [31:0] a, input logic [7:0] s);
      logic signed [31:0] v;
      exp_t e;
      v = a;
`ifdef CORDIC_PRESTAGE_CLAMP_EN
      if (v > PI) v = PI;
      else if (v < -PI) v = -PI;
`endif
      e.seq = s;
      if (v > PH)       begin e.z = v - PI; e.q = 1'b1; end
      else if (v < -PH) begin e.z = v + PI; e.q = 1'b1; end
      else              begin e.z = v;      e.q = 1'b0; end
      return e;
   endfunction

   // One clock of stimulus; handshakes are evaluated just after the falling edge.
   task automatic cycle(input logic v, input logic [31:0] a, input logic r, output logic acc);
      exp_t e;
      @(negedge clk);
      io.in_valid = v; io.angle_in = a; io.out_ready = r;
      #1;
      acc = v && io.in_ready;
      if (io.out_valid && r) begin
         npop++;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected_output: got seq %0d, none expected", io.seq_out);
         end else begin
            e = sb.pop_front();
            if ({io.x_out, io.y_out, io.z_out, io.quad_neg, io.seq_out} !== {K_INIT, 32'd0, e.z, e.q, e.seq}) begin
               fails++;
               $display("FAIL sb_output: got x=%h y=%h z=%h q=%b seq=%0d, want x=%h y=0 z=%h q=%b seq=%0d",
                        io.x_out, io.y_out, io.z_out, io.quad_neg, io.seq_out, K_INIT, e.z, e.q, e.seq);
            end
         end
      end
      if (acc) begin
         sb.push_back(model(a, exp_seq));
         exp_seq++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; io.in_valid = 1'b0; io.angle_in = '0; io.out_ready = 1'b0;
      sb.delete(); exp_seq = 8'd0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain();
      logic acc;
      for (int k = 0; k < 20 && sb.size() != 0; k++) cycle(1'b0, 32'd0, 1'b1, acc);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout: %0d samples still expected", sb.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; io.in_valid = 1'b0; io.angle_in = '0; io.out_ready = 1'b0;
      sb.delete(); exp_seq = 8'd0;
      #1;
      tests++;
      if ({io.out_valid, io.in_ready, io.range_err} !== 3'b000) begin
         fails++;
         $display("FAIL reset_flags: got valid/ready/err=%b%b%b want 000", io.out_valid, io.in_ready, io.range_err);
      end
      tests++;
      if ({io.x_out, io.y_out, io.z_out, io.quad_neg, io.seq_out} !== '0) begin
         fails++;
         $display("FAIL reset_data: got x=%h y=%h z=%h q=%b seq=%0d want all 0",
                  io.x_out, io.y_out, io.z_out, io.quad_neg, io.seq_out);
      end
      repeat (2) @(negedge clk);
      tests++;
      if (io.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready_held: got %b want 0", io.in_ready);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (io.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready_release: got %b want 1", io.in_ready);
      end
   endtask

   task automatic test_reduction();
      logic acc;
      logic [31:0] tbl [6];
      tbl = '{32'h6487ED51, 32'hCDBC0957, 32'h3243F6A9, 32'h3243F6AA, 32'h9B7812AF, 32'hCDBC0956};
      cycle(1'b1, 32'h10000000, 1'b1, acc);
      @(posedge clk); #1;
      tests++;
      if ({io.out_valid, io.x_out, io.y_out, io.z_out, io.quad_neg, io.seq_out} !==
          {1'b1, 32'h136E9DB5, 32'd0, 32'h10000000, 1'b0, 8'd0}) begin
         fails++;
         $display("FAIL first_sample: got v=%b x=%h y=%h z=%h q=%b seq=%0d want v=1 x=136e9db5 y=0 z=10000000 q=0 seq=0",
                  io.out_valid, io.x_out, io.y_out, io.z_out, io.quad_neg, io.seq_out);
      end
      foreach (tbl[i]) cycle(1'b1, tbl[i], 1'b1, acc);
      drain();
      repeat (2) cycle(1'b0, 32'd0, 1'b1, acc);
      tests++;
      if ({io.out_valid, io.z_out, io.quad_neg, io.x_out} !== {1'b0, 32'h3243F6A7, 1'b1, K_INIT}) begin
         fails++;
         $display("FAIL idle_hold: got v=%b z=%h q=%b x=%h want v=0 z=3243f6a7 q=1 x=%h",
                  io.out_valid, io.z_out, io.quad_neg, io.x_out, K_INIT);
      end
   endtask

   task automatic test_backpressure();
      logic acc;
      logic [31:0] held;
      int k;
      do_reset();
      cycle(1'b1, 32'h01000000, 1'b0, acc);
      cycle(1'b1, 32'h50000000, 1'b0, acc);
      cycle(1'b1, 32'hA0000000, 1'b0, acc);
      tests++;
      if (io.in_ready !== 1'b0 || acc) begin
         fails++;
         $display("FAIL full_ready: got in_ready=%b want 0", io.in_ready);
      end
      held = io.z_out;
      cycle(1'b1, 32'hA0000000, 1'b0, acc);
      tests++;
      if ({io.out_valid, io.z_out, io.seq_out, io.in_ready} !== {1'b1, held, 8'd0, 1'b0}) begin
         fails++;
         $display("FAIL stall_hold: got v=%b z=%h seq=%0d rdy=%b want v=1 z=%h seq=0 rdy=0",
                  io.out_valid, io.z_out, io.seq_out, io.in_ready, held);
      end
      acc = 1'b0;
      for (k = 0; k < 10 && !acc; k++) cycle(1'b1, 32'hA0000000, 1'b1, acc);
      tests++;
      if (!acc) begin
         fails++;
         $display("FAIL third_accept: got no accept, want accept within 10 cycles");
      end
      drain();
      tests++;
      if (exp_seq !== 8'd3) begin
         fails++;
         $display("FAIL bp_accept_count: got %0d want 3", exp_seq);
      end
   endtask

   task automatic test_back_to_back();
      logic acc;
      logic [31:0] a;
      int bad_acc = 0, bad_vld = 0, p0;
      do_reset();
      p0 = npop;
      for (int i = 0; i < 300; i++) begin
         a = $urandom_range(0, 32'hC90FDAA2) - PI;
         cycle(1'b1, a, 1'b1, acc);
         if (!acc) bad_acc++;
         if (i > 0 && io.out_valid !== 1'b1) bad_vld++;
      end
      drain();
      tests++;
      if (bad_acc != 0 || bad_vld != 0) begin
         fails++;
         $display("FAIL stream_rate: got %0d stalls %0d bubbles want 0 0", bad_acc, bad_vld);
      end
      tests++;
      if (npop - p0 != 300) begin
         fails++;
         $display("FAIL stream_count: got %0d outputs want 300", npop - p0);
      end
   endtask

   task automatic test_reset_mid();
      logic acc;
      do_reset();
      cycle(1'b1, 32'h11111111, 1'b0, acc);
      cycle(1'b1, 32'h22222222, 1'b0, acc);
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if ({io.out_valid, io.in_ready, io.x_out, io.y_out, io.z_out, io.quad_neg, io.seq_out} !== '0) begin
         fails++;
         $display("FAIL mid_reset: got v=%b rdy=%b x=%h y=%h z=%h q=%b seq=%0d want all 0",
                  io.out_valid, io.in_ready, io.x_out, io.y_out, io.z_out, io.quad_neg, io.seq_out);
      end
      sb.delete(); exp_seq = 8'd0;
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, 32'h33333333, 1'b1, acc);
      drain();
      tests++;
      if (npop == 0 || io.seq_out !== 8'd0) begin
         fails++;
         $display("FAIL post_reset_seq: got %0d want 0", io.seq_out);
      end
   endtask

   task automatic test_range();
      logic acc;
      do_reset();
      cycle(1'b1, 32'h7FFFFFFF, 1'b1, acc);
      cycle(1'b1, 32'h10000000, 1'b1, acc);
      drain();
      repeat (3) cycle(1'b0, 32'd0, 1'b1, acc);
`ifdef CORDIC_PRESTAGE_CLAMP_EN
      tests++;
      if (io.range_err !== 1'b1) begin
         fails++;
         $display("FAIL range_err_sticky: got %b want 1", io.range_err);
      end
      do_reset();
      #1;
      tests++;
      if (io.range_err !== 1'b0) begin
         fails++;
         $display("FAIL range_err_reset: got %b want 0", io.range_err);
      end
`else
      tests++;
      if (io.range_err !== 1'b0) begin
         fails++;
         $display("FAIL range_err_tied: got %b want 0", io.range_err);
      end
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_reduction();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_range();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
